// File: rtl/fp16_mult_arbiter_if.sv
// Bundle of request, multiplier-side and response signals around the FP16 multiplier arbiter.
// Latency: none (wires only).
// Backpressure: per-requester valid/ready on the request side; the response bus has no backpressure.
//
// Ports (as seen from the arbiter, i.e. the slave modport):
//   req_valid/req_ready  per-requester handshake, req_a/req_b packed 16 bits per requester
//   mul_valid/mul_a/mul_b issue towards the multiplier, mul_result/mul_flags back from it
//   rsp_valid/rsp_id/rsp_result/rsp_flags  shared ID-tagged response bus
interface fp16_mult_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [16*NUM_REQ-1:0] req_a;
    logic [16*NUM_REQ-1:0] req_b;

    logic                  mul_valid;
    logic [15:0]           mul_a;
    logic [15:0]           mul_b;
    logic [15:0]           mul_result;
    logic [4:0]            mul_flags;

    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [15:0]           rsp_result;
    logic [4:0]            rsp_flags;

    // Environment side: requesters plus the multiplier itself.
    modport master (
        output req_valid, req_a, req_b, mul_result, mul_flags,
        input  req_ready, mul_valid, mul_a, mul_b,
               rsp_valid, rsp_id, rsp_result, rsp_flags
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_a, req_b, mul_result, mul_flags,
        output req_ready, mul_valid, mul_a, mul_b,
               rsp_valid, rsp_id, rsp_result, rsp_flags
    );
endinterface

// File: rtl/fp16_mult_arbiter.sv
// Round-robin arbiter sharing one FP16 multiplier among NUM_REQ requesters, ID-tagged responses.
// Latency: handshake in T -> mul_valid in T+1 -> rsp_valid in T+2+MUL_LAT.
// Backpressure: combinational req_ready, throttled per requester at MAX_OUT outstanding; responses cannot stall.
//
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   bus        fp16_mult_arbiter_if.slave: request handshakes, multiplier issue/return, response bus
module fp16_mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 0,
    parameter int MAX_OUT = 3
) (
    input  logic                clk,
    input  logic                rst,
    fp16_mult_arbiter_if.slave  bus
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW  = $clog2(MAX_OUT + 1);

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } tag_t;

    // Registered state
    logic [IDW-1:0] prio_ptr_q;
    logic           mul_valid_q;
    logic [15:0]    mul_a_q;
    logic [15:0]    mul_b_q;
    logic [IDW-1:0] mul_id_q;
    logic           rsp_valid_q;
    logic [IDW-1:0] rsp_id_q;
    logic [15:0]    rsp_result_q;
    logic [4:0]     rsp_flags_q;
    logic [CW-1:0]  out_cnt_q [NUM_REQ];

    // Grant logic
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_vld;
    logic [IDW-1:0]     gnt_id;
    logic [IDW:0]       scan;

    always_comb begin
        elig    = '0;
        gnt     = '0;
        gnt_vld = 1'b0;
        gnt_id  = '0;
        scan    = '0;
        // Registered counts only: a response retiring this cycle frees the slot next cycle.
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = bus.req_valid[i] && (out_cnt_q[i] < CW'(MAX_OUT));
        end
        // First eligible requester at or after the pointer, wrapping.
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, prio_ptr_q} + (IDW+1)'(k);
            if (scan >= (IDW+1)'(NUM_REQ)) begin
                scan = scan - (IDW+1)'(NUM_REQ);
            end
            if (!gnt_vld && elig[scan[IDW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_id  = scan[IDW-1:0];
            end
        end
        if (rst) begin
            gnt_vld = 1'b0;
        end
        if (gnt_vld) begin
            gnt[gnt_id] = 1'b1;
        end
    end

    assign bus.req_ready = gnt;

    // Tag pipeline: {valid, id} follows the issue register so it lines up with mul_result.
    tag_t issue_tag;
    tag_t tag_out;

    assign issue_tag = '{vld: mul_valid_q, id: mul_id_q};

    generate
        if (MUL_LAT == 0) begin : g_comb_mul
            assign tag_out = issue_tag;
        end else begin : g_pipe_mul
            tag_t tag_q [MUL_LAT];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < MUL_LAT; s++) begin
                        tag_q[s] <= '0;
                    end
                end else begin
                    tag_q[0] <= issue_tag;
                    for (int s = 1; s < MUL_LAT; s++) begin
                        tag_q[s] <= tag_q[s-1];
                    end
                end
            end
            assign tag_out = tag_q[MUL_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_ptr_q   <= '0;
            mul_valid_q  <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_id_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                out_cnt_q[i] <= '0;
            end
        end else begin
            // Issue register: operands hold when idle, only the valid drops.
            mul_valid_q <= gnt_vld;
            if (gnt_vld) begin
                mul_a_q    <= bus.req_a[{gnt_id, 4'b0000} +: 16];
                mul_b_q    <= bus.req_b[{gnt_id, 4'b0000} +: 16];
                mul_id_q   <= gnt_id;
                prio_ptr_q <= (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            end

            // Response register: one-cycle pulse, data fields hold otherwise.
            rsp_valid_q <= tag_out.vld;
            if (tag_out.vld) begin
                rsp_id_q     <= tag_out.id;
                rsp_result_q <= bus.mul_result;
                rsp_flags_q  <= bus.mul_flags;
            end

            // Outstanding counts: the retiring response is the one currently on rsp_*.
            for (int i = 0; i < NUM_REQ; i++) begin
                if ((gnt_vld && gnt_id == IDW'(i)) && !(rsp_valid_q && rsp_id_q == IDW'(i))) begin
                    out_cnt_q[i] <= out_cnt_q[i] + 1'b1;
                end else if (!(gnt_vld && gnt_id == IDW'(i)) && (rsp_valid_q && rsp_id_q == IDW'(i))) begin
                    out_cnt_q[i] <= out_cnt_q[i] - 1'b1;
                end
            end
        end
    end

    assign bus.mul_valid  = mul_valid_q;
    assign bus.mul_a      = mul_a_q;
    assign bus.mul_b      = mul_b_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;
endmodule

// File: tb/tb_fp16_mult_arbiter.sv
// Bench for fp16_mult_arbiter: default instance under a cycle-accurate scoreboard, plus a throttled instance.
// Latency: checks T+1 issue and T+2+MUL_LAT response timing.
// Backpressure: exercises MAX_OUT throttling and rotation fairness.
module tb_fp16_mult_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference FP16 multiply: normals, flush-to-zero, truncation, NaN/Inf handling.
    function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        logic [21:0] p;
        int          e;
        logic [9:0]  m;
        s = a[15] ^ b[15];
        if ((a[14:10] == 5'h1F && a[9:0] != 0) || (b[14:10] == 5'h1F && b[9:0] != 0)) return 16'h7E00;
        if (a[14:10] == 5'h1F || b[14:10] == 5'h1F) begin
            if (a[14:10] == 5'h00 || b[14:10] == 5'h00) return 16'h7E00;
            return {s, 5'h1F, 10'h000};
        end
        if (a[14:10] == 5'h00 || b[14:10] == 5'h00) return {s, 15'h0000};
        p = {1'b1, a[9:0]} * {1'b1, b[9:0]};
        e = int'(a[14:10]) + int'(b[14:10]) - 15;
        if (p[21]) begin
            m = p[20:11];
            e++;
        end else begin
            m = p[19:10];
        end
        if (e >= 31) return {s, 5'h1F, 10'h000};
        if (e <= 0) return {s, 15'h0000};
        return {s, e[4:0], m};
    endfunction

    // Flags {any, ANaN, BNaN, AInf, BInf}; an all-ones A operand makes the stub raise every flag.
    function automatic logic [4:0] fp16_flags(input logic [15:0] a, input logic [15:0] b);
        logic an, bn, ai, bi;
        if (a == 16'hFFFF) return 5'h1F;
        an = (a[14:10] == 5'h1F) && (a[9:0] != 0);
        bn = (b[14:10] == 5'h1F) && (b[9:0] != 0);
        ai = (a[14:10] == 5'h1F) && (a[9:0] == 0);
        bi = (b[14:10] == 5'h1F) && (b[9:0] == 0);
        return {an | bn | ai | bi, an, bn, ai, bi};
    endfunction

    fp16_mult_arbiter_if #(.NUM_REQ(4)) d_if ();
    fp16_mult_arbiter_if #(.NUM_REQ(4)) t_if ();

    fp16_mult_arbiter #(.NUM_REQ(4), .MUL_LAT(0), .MAX_OUT(3)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (d_if)
    );

    fp16_mult_arbiter #(.NUM_REQ(4), .MUL_LAT(2), .MAX_OUT(1)) u_thr (
        .clk (clk),
        .rst (rst),
        .bus (t_if)
    );

    // Combinational multiplier for the default instance, two-stage one for the throttled instance.
    assign d_if.mul_result = fp16_mul(d_if.mul_a, d_if.mul_b);
    assign d_if.mul_flags  = fp16_flags(d_if.mul_a, d_if.mul_b);

    logic [15:0] t_p1, t_p2;
    logic [4:0]  t_f1, t_f2;
    always @(posedge clk) begin
        t_p1 <= fp16_mul(t_if.mul_a, t_if.mul_b);
        t_f1 <= fp16_flags(t_if.mul_a, t_if.mul_b);
        t_p2 <= t_p1;
        t_f2 <= t_f1;
    end
    assign t_if.mul_result = t_p2;
    assign t_if.mul_flags  = t_f2;

    // Scoreboard for the default instance: expected grants, issue and responses.
    typedef struct {
        int          id;
        logic [15:0] res;
        logic [4:0]  flg;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          m_cnt[4];
    int          m_ptr = 0;
    bit          m_prev_hs = 1'b0;
    logic [15:0] m_pa, m_pb;
    int          cyc = 0;

    always @(negedge clk) begin
        int   eg;
        exp_t e;
        if (rst) begin
            check("rdy_in_rst", 32'(d_if.req_ready), 32'h0);
            sb.delete();
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            m_ptr     = 0;
            m_prev_hs = 1'b0;
        end else begin
            eg = -1;
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_ptr + k) % 4;
                if (eg < 0 && d_if.req_valid[i] && m_cnt[i] < 3) eg = i;
            end
            check("req_ready", 32'(d_if.req_ready), (eg < 0) ? 32'h0 : (32'h1 << eg));
            check("mul_valid", 32'(d_if.mul_valid), 32'(m_prev_hs));
            if (m_prev_hs) begin
                check("mul_a", 32'(d_if.mul_a), 32'(m_pa));
                check("mul_b", 32'(d_if.mul_b), 32'(m_pb));
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                check("rsp_valid", 32'(d_if.rsp_valid), 32'h1);
                check("rsp_id", 32'(d_if.rsp_id), 32'(e.id));
                check("rsp_result", 32'(d_if.rsp_result), 32'(e.res));
                check("rsp_flags", 32'(d_if.rsp_flags), 32'(e.flg));
                m_cnt[e.id]--;
            end else begin
                check("rsp_valid_idle", 32'(d_if.rsp_valid), 32'h0);
            end
            m_prev_hs = (eg >= 0);
            if (eg >= 0) begin
                m_pa = d_if.req_a[16*eg +: 16];
                m_pb = d_if.req_b[16*eg +: 16];
                sb.push_back('{eg, fp16_mul(m_pa, m_pb), fp16_flags(m_pa, m_pb), cyc + 2});
                m_cnt[eg]++;
                m_ptr = (eg + 1) % 4;
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        bit found;
        d_if.req_valid = '0; d_if.req_a = '0; d_if.req_b = '0;
        t_if.req_valid = '0; t_if.req_a = '0; t_if.req_b = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_mul_valid", 32'(d_if.mul_valid), 32'h0);
        check("rst_mul_a", 32'(d_if.mul_a), 32'h0);
        check("rst_rsp_valid", 32'(d_if.rsp_valid), 32'h0);
        check("rst_rsp_result", 32'(d_if.rsp_result), 32'h0);
        check("rst_rsp_id", 32'(d_if.rsp_id), 32'h0);
        check("rst_rsp_flags", 32'(d_if.rsp_flags), 32'h0);
        step();

        // Single op on requester 2: 1.0 x 2.0
        d_if.req_valid = 4'b0100;
        d_if.req_a[47:32] = 16'h3C00;
        d_if.req_b[47:32] = 16'h4000;
        @(negedge clk);
        check("single_ready", 32'(d_if.req_ready), 32'h4);
        step();
        d_if.req_valid = '0;
        @(negedge clk);
        check("single_mul_valid", 32'(d_if.mul_valid), 32'h1);
        check("single_mul_a", 32'(d_if.mul_a), 32'h3C00);
        check("single_mul_b", 32'(d_if.mul_b), 32'h4000);
        check("single_cnt_t1", 32'(u_dut.out_cnt_q[2]), 32'h1);
        step();
        @(negedge clk);
        check("single_rsp_valid", 32'(d_if.rsp_valid), 32'h1);
        check("single_rsp_id", 32'(d_if.rsp_id), 32'h2);
        check("single_rsp_result", 32'(d_if.rsp_result), 32'h4000);
        check("single_rsp_flags", 32'(d_if.rsp_flags), 32'h0);
        check("single_cnt_t2", 32'(u_dut.out_cnt_q[2]), 32'h1);
        step();
        @(negedge clk);
        check("single_cnt_t3", 32'(u_dut.out_cnt_q[2]), 32'h0);
        step();

        // Round-robin with all requesters valid
        do_reset();
        for (int i = 0; i < 4; i++) begin
            d_if.req_a[16*i +: 16] = 16'h3E00;
            d_if.req_b[16*i +: 16] = 16'h3C00 + 16'(i * 16'h0400);
        end
        d_if.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rr_grant", 32'(d_if.req_ready), 32'h1 << (k % 4));
            step();
        end
        d_if.req_valid = '0;
        step();
        step();

        // 1.5 x 1.5 on requester 1
        d_if.req_valid = 4'b0010;
        d_if.req_a[31:16] = 16'h3E00;
        d_if.req_b[31:16] = 16'h3E00;
        step();
        d_if.req_valid = '0;
        step();
        @(negedge clk);
        check("sq15_rsp_valid", 32'(d_if.rsp_valid), 32'h1);
        check("sq15_rsp_id", 32'(d_if.rsp_id), 32'h1);
        check("sq15_rsp_result", 32'(d_if.rsp_result), 32'h4080);
        step();

        // Exception flags pass through
        d_if.req_valid = 4'b0010;
        d_if.req_a[31:16] = 16'hFFFF;
        d_if.req_b[31:16] = 16'h3C00;
        step();
        d_if.req_valid = '0;
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            @(negedge clk);
            if (d_if.rsp_valid) begin
                found = 1'b1;
                check("exc_flags", 32'(d_if.rsp_flags), 32'h1F);
                check("exc_id", 32'(d_if.rsp_id), 32'h1);
            end
            step();
        end
        if (!found) check("exc_timeout", 32'h0, 32'h1);

        // Reset mid-flight
        for (int i = 1; i < 4; i++) begin
            d_if.req_a[16*i +: 16] = 16'h4000;
            d_if.req_b[16*i +: 16] = 16'h3C00 + 16'(i * 16'h0400);
        end
        d_if.req_valid = 4'b1110;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        d_if.req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("midrst_no_rsp", 32'(d_if.rsp_valid), 32'h0);
            check("midrst_no_mul", 32'(d_if.mul_valid), 32'h0);
            if (k == 0) begin
                for (int i = 0; i < 4; i++) check("midrst_cnt", 32'(u_dut.out_cnt_q[i]), 32'h0);
            end
            step();
        end
        d_if.req_valid = 4'b1100;
        @(negedge clk);
        check("midrst_next_grant", 32'(d_if.req_ready), 32'h4);
        step();
        d_if.req_valid = '0;
        step();
        step();

        // Throttle: MAX_OUT=1, MUL_LAT=2, requester 0 alone; 2.0 x 3.0
        do_reset();
        t_if.req_a[15:0] = 16'h4000;
        t_if.req_b[15:0] = 16'h4200;
        t_if.req_valid = 4'b0001;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check("thr_ready", 32'(t_if.req_ready), (k % 5 == 0) ? 32'h1 : 32'h0);
            check("thr_rsp_valid", 32'(t_if.rsp_valid), (k % 5 == 4) ? 32'h1 : 32'h0);
            if (k % 5 == 4) begin
                check("thr_rsp_result", 32'(t_if.rsp_result), 32'h4600);
                check("thr_rsp_id", 32'(t_if.rsp_id), 32'h0);
            end
            step();
        end
        t_if.req_valid = '0;

        // Fairness under throttle: requesters 0 and 3
        do_reset();
        t_if.req_a[63:48] = 16'h3C00;
        t_if.req_b[63:48] = 16'h4400;
        t_if.req_valid = 4'b1001;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("fair_ready", 32'(t_if.req_ready),
                  (k % 5 == 0) ? 32'h1 : ((k % 5 == 1) ? 32'h8 : 32'h0));
            step();
        end
        t_if.req_valid = '0;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
